fpu_divsqrt_scheduler: RTL
==========================

// Module: fpu_divsqrt_scheduler
// PURPOSE
// Shares one iterative FP divide/sqrt unit between NUM_REQ requesters (integer pipe, FP pipe, ...).
// Round-robin arbitration; latches winner's operands; issues one op; waits for done or timeout.
// Holds the fpu::fpu_result_t-formatted result (41 b) until the owning requester accepts it.
// One op in flight; sits between issue stage and the shared fpu div/sqrt datapath.
// PARAMETERS
// NUM_REQ         4   number of requesters (>=2)
// TIMEOUT_CYCLES  64  max WAIT cycles before forced NaN error result (>=2)
// PORTS
// clk             in   1          clock
// rst             in   1          reset, asynchronous, active-high
// req_valid       in   NUM_REQ    request valid per requester
// req_ready       out  NUM_REQ    request accepted (one-hot or zero)
// req_op          in   NUM_REQ    0=div (a/b), 1=sqrt (a; b ignored)
// req_a           in   NUM_REQ*32 operand a per requester (fpu_float_t)
// req_b           in   NUM_REQ*32 operand b per requester
// req_mode        in   NUM_REQ*2  fpu_round_mode_t per requester
// unit_start      out  1          one-cycle issue pulse to unit
// unit_op         out  1          latched op
// unit_a/unit_b   out  32 each    latched operands, stable from ISSUE through WAIT
// unit_mode       out  2          latched round mode
// unit_done       in   1          unit result valid (single-cycle pulse)
// unit_result     in   41         fpu_result_t from unit
// resp_valid      out  NUM_REQ    response valid, one-hot to owner
// resp_ready      in   NUM_REQ    response accepted
// resp_result     out  41         fpu_result_t to owner
// resp_error      out  1          1 = result forced by timeout
// busy            out  1          state != IDLE
// BEHAVIOUR
// - States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Registers: state, owner, last_grant, op latch,
//   result latch, error, timer [$clog2(TIMEOUT_CYCLES)-1:0].
// - Reset: state=IDLE, last_grant=NUM_REQ-1 (req 0 wins first); all outputs 0; latches 0.
// - IDLE: winner = first valid scanning last_grant+1, +2, ... (mod NUM_REQ).
//   req_ready[winner]=1 combinationally from state and req_valid, same cycle; handshake = valid&ready.
//   On handshake: latch op/a/b/mode, owner=winner, go to ISSUE. req_ready=0 in all other states.
// - ISSUE: unit_start=1 for exactly this cycle; timer<=0; go to WAIT.
// - WAIT: if unit_done: latch unit_result, error=0, go to RESP.
//   Else if timer==TIMEOUT_CYCLES-1: result={sign=latched a[31], nan=1, inf=0, zero=0, guard=0,
//   exponent=8'hFF, mantissa=24'hFFFFFF, mode=latched}, error=1, go to RESP. Else timer++.
//   unit_done wins over timeout in the same cycle.
// - RESP: resp_valid[owner]=1; resp_result/resp_error stable until resp_ready[owner].
//   On accept: last_grant=owner, go to IDLE. resp_ready of non-owners ignored.
// - unit_done outside WAIT ignored (no state or latch change).
// - Min latency: handshake T, unit_start T+1, done T+2 earliest, resp_valid T+3.
//   Next request accepted no earlier than the cycle after resp accept (IDLE cycle).
// - Reset mid-operation: async return to IDLE; in-flight op dropped, no response; unit shares rst.
// - Requester dropping req_valid before handshake is legal; arbitration re-evaluates each cycle.
// TESTING
// 1. req0 div a=32'h40400000 b=32'h3F800000 mode=EVEN; model done 4 cyc after start
//    -> req_ready[0]@T, unit_start@T+1 only, resp_valid[0]@T+6 with model result, resp_error=0.
// 2. All four req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0; no requester skipped.
// 3. Model never asserts done, TIMEOUT_CYCLES=16 -> resp_valid@T+18, resp_error=1, nan=1, exp=8'hFF.
// 4. resp_ready[owner]=0 for 10 cycles -> resp_result stable, req_ready=0, unit_start=0 throughout.
// 5. rst pulsed during WAIT -> outputs 0 immediately; no resp; next grant goes to req 0.
// 6. unit_done pulsed in IDLE and in RESP -> no state or result change; done+timeout same cycle -> error=0.

Source files
------------

// File: rtl/fpu_divsqrt_scheduler_if.sv
// fpu_divsqrt_scheduler_if: requester, unit and response signals of the shared div/sqrt scheduler.
// master = environment (requesters + unit), slave = scheduler.
interface fpu_divsqrt_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_op;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ*2-1:0]  req_mode;
    logic                  unit_start;
    logic                  unit_op;
    logic [31:0]           unit_a;
    logic [31:0]           unit_b;
    logic [1:0]            unit_mode;
    logic                  unit_done;
    logic [40:0]           unit_result;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [40:0]           resp_result;
    logic                  resp_error;
    logic                  busy;

    modport master (
        output req_valid, req_op, req_a, req_b, req_mode, unit_done, unit_result, resp_ready,
        input  req_ready, unit_start, unit_op, unit_a, unit_b, unit_mode,
               resp_valid, resp_result, resp_error, busy
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_mode, unit_done, unit_result, resp_ready,
        output req_ready, unit_start, unit_op, unit_a, unit_b, unit_mode,
               resp_valid, resp_result, resp_error, busy
    );
endinterface

// File: rtl/fpu_divsqrt_scheduler.sv
// fpu_divsqrt_scheduler: round-robin front end sharing one iterative FP div/sqrt unit, one op in flight.
// Result layout (41b): {2'b0, sign, nan, inf, zero, guard, exponent[7:0], mantissa[23:0], mode[1:0]}.
module fpu_divsqrt_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                    clk,
    input logic                    rst,
    fpu_divsqrt_scheduler_if.slave sch
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q;
    logic [OW-1:0]      owner_q, last_q, winner;
    logic [TW-1:0]      timer_q;
    logic               found, op_q, start_q, err_q;
    logic [31:0]        a_q, b_q;
    logic [1:0]         mode_q;
    logic [40:0]        res_q;
    logic [NUM_REQ-1:0] rvalid_q;

    // Scan downwards so the nearest valid requester after last_q is the final assignment.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (sch.req_valid[(int'(last_q) + k) % NUM_REQ]) begin
                winner = OW'((int'(last_q) + k) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    assign sch.req_ready   = (state_q == IDLE && found) ? NUM_REQ'(1) << winner : '0;
    assign sch.unit_start  = start_q;
    assign sch.unit_op     = op_q;
    assign sch.unit_a      = a_q;
    assign sch.unit_b      = b_q;
    assign sch.unit_mode   = mode_q;
    assign sch.resp_valid  = rvalid_q;
    assign sch.resp_result = res_q;
    assign sch.resp_error  = err_q;
    assign sch.busy        = state_q != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            last_q   <= OW'(NUM_REQ - 1);
            timer_q  <= '0;
            op_q     <= 1'b0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            res_q    <= '0;
            rvalid_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    op_q    <= sch.req_op[winner];
                    a_q     <= sch.req_a[winner*32 +: 32];
                    b_q     <= sch.req_b[winner*32 +: 32];
                    mode_q  <= sch.req_mode[winner*2 +: 2];
                    owner_q <= winner;
                    start_q <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: if (sch.unit_done) begin
                    res_q    <= sch.unit_result;
                    err_q    <= 1'b0;
                    rvalid_q <= NUM_REQ'(1) << owner_q;
                    state_q  <= RESP;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    res_q    <= {2'b00, a_q[31], 1'b1, 3'b000, 8'hFF, 24'hFFFFFF, mode_q};
                    err_q    <= 1'b1;
                    rvalid_q <= NUM_REQ'(1) << owner_q;
                    state_q  <= RESP;
                end else begin
                    timer_q <= timer_q + TW'(1);
                end
                RESP: if (sch.resp_ready[owner_q]) begin
                    rvalid_q <= '0;
                    last_q   <= owner_q;
                    state_q  <= IDLE;
                end
            endcase
        end
    end
endmodule
